// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// No logic, no latency, no flow control.
package ifetch_pkg;

  typedef enum logic [2:0] {
    ALU_PASSB = 3'b000,
    ALU_ADD   = 3'b010,
    ALU_SUB   = 3'b011,
    ALU_AND   = 3'b100,
    ALU_OR    = 3'b101,
    ALU_XOR   = 3'b110
  } alu_ctrl_e;

  localparam int PC_STEP  = 4;
  localparam int PC_RESET = 0;

  // Immediate field positions inside the 32-bit instruction word
  localparam int IMM19_LSB = 5;
  localparam int IMM19_MSB = 23;
  localparam int IMM26_MSB = 25;

endpackage

// File: rtl/instr_fetch_unit_alu.sv
// Combinational TotalBit-wide ALU with N/Z/C/V flags; zero latency.
// No flow control; subtraction is A + ~B + 1 so carry is "no borrow".
module alu
  import ifetch_pkg::*;
#(
  parameter int TotalBit = 64
) (
  input  logic [TotalBit-1:0] a,
  input  logic [TotalBit-1:0] b,
  input  logic [2:0]          cntrl,
  output logic [TotalBit-1:0] result,
  output logic                negative,
  output logic                zero,
  output logic                carry_out,
  output logic                overflow
);

  logic              is_sub;
  logic              is_arith;
  logic [TotalBit-1:0] b_eff;
  logic [TotalBit:0]   sum;

  always_comb begin
    is_sub   = (alu_ctrl_e'(cntrl) == ALU_SUB);
    is_arith = is_sub || (alu_ctrl_e'(cntrl) == ALU_ADD);
    b_eff    = is_sub ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {{TotalBit{1'b0}}, is_sub};

    case (alu_ctrl_e'(cntrl))
      ALU_PASSB: result = b;
      ALU_ADD,
      ALU_SUB:   result = sum[TotalBit-1:0];
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      default:   result = '0;
    endcase

    negative  = result[TotalBit-1];
    zero      = (result == '0);
    carry_out = is_arith & sum[TotalBit];
    // Operands of equal sign producing a result of the other sign
    overflow  = is_arith & (a[TotalBit-1] == b_eff[TotalBit-1])
                         & (sum[TotalBit-1] != a[TotalBit-1]);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, PC+4 / branch-target select; 1-cycle PC update, Instr is zero latency.
// No backpressure: PC advances every clock. Optional debug flag ports under IFETCH_FLAGS_EN.
module instr_fetch_unit
  import ifetch_pkg::*;
#(
  parameter int TotalBit = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                brtaken,
  input  logic                uncondBr,
  input  logic [31:0]         imem_rdata,
  output logic [TotalBit-1:0] imem_addr,
  output logic [31:0]         Instr
`ifdef IFETCH_FLAGS_EN
  ,
  output logic                seq_carry,
  output logic                br_overflow
`endif
);

  logic [TotalBit-1:0] pc;
  logic [TotalBit-1:0] adder19;
  logic [TotalBit-1:0] adder26;
  logic [TotalBit-1:0] imm_sel;
  logic [TotalBit-1:0] offset;
  logic [TotalBit-1:0] seq_pc;
  logic [TotalBit-1:0] br_pc;
  logic [TotalBit-1:0] new_pc;

  logic seq_c, seq_v, br_c, br_v;
  logic seq_n_unused, seq_z_unused, br_n_unused, br_z_unused;

  assign imem_addr = pc;
  assign Instr     = imem_rdata;

  assign adder19 = {{(TotalBit-(IMM19_MSB-IMM19_LSB+1)){Instr[IMM19_MSB]}},
                    Instr[IMM19_MSB:IMM19_LSB]};
  assign adder26 = {{(TotalBit-(IMM26_MSB+1)){Instr[IMM26_MSB]}},
                    Instr[IMM26_MSB:0]};
  assign imm_sel = uncondBr ? adder26 : adder19;
  // Word-scale the offset; the two MSBs fall off
  assign offset  = {imm_sel[TotalBit-3:0], 2'b00};

  alu #(.TotalBit(TotalBit)) u_seq_alu (
    .a         (pc),
    .b         (TotalBit'(PC_STEP)),
    .cntrl     (ALU_ADD),
    .result    (seq_pc),
    .negative  (seq_n_unused),
    .zero      (seq_z_unused),
    .carry_out (seq_c),
    .overflow  (seq_v)
  );

  alu #(.TotalBit(TotalBit)) u_br_alu (
    .a         (pc),
    .b         (offset),
    .cntrl     (ALU_ADD),
    .result    (br_pc),
    .negative  (br_n_unused),
    .zero      (br_z_unused),
    .carry_out (br_c),
    .overflow  (br_v)
  );

  assign new_pc = brtaken ? br_pc : seq_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= TotalBit'(PC_RESET);
    else        pc <= new_pc;
  end

`ifdef IFETCH_FLAGS_EN
  logic flags_unused;
  assign seq_carry    = seq_c;
  assign br_overflow  = br_v;
  assign flags_unused = seq_v ^ br_c;
`else
  logic flags_unused;
  assign flags_unused = seq_c ^ seq_v ^ br_c ^ br_v;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + randomized check of instr_fetch_unit against a spec-level PC model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        brtaken;
  logic        uncondBr;
  logic [31:0] imem_rdata;
  logic [63:0] imem_addr;
  logic [31:0] Instr;
`ifdef IFETCH_FLAGS_EN
  logic        seq_carry;
  logic        br_overflow;
`endif

  logic [63:0] a, b, result;
  logic [2:0]  cntrl;
  logic        negative, zero, carry_out, overflow;

  int ntests = 0;
  int nfail  = 0;
  logic [63:0] pc_m;

  always #5 clk = ~clk;

  instr_fetch_unit #(.TotalBit(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .brtaken    (brtaken),
    .uncondBr   (uncondBr),
    .imem_rdata (imem_rdata),
    .imem_addr  (imem_addr),
    .Instr      (Instr)
`ifdef IFETCH_FLAGS_EN
    ,
    .seq_carry  (seq_carry),
    .br_overflow(br_overflow)
`endif
  );

  alu #(.TotalBit(64)) u_alu (
    .a(a), .b(b), .cntrl(cntrl), .result(result),
    .negative(negative), .zero(zero), .carry_out(carry_out), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Branch offset in bytes: signed immediate times four, modulo 2^64
  function automatic logic [63:0] br_off(input logic [31:0] w, input logic ub);
    longint imm;
    imm = ub ? longint'($signed(w[25:0])) : longint'($signed(w[23:5]));
    return 64'(imm * 4);
  endfunction

  function automatic logic [63:0] ref_next(input logic [63:0] pc, input logic [31:0] w,
                                           input logic br, input logic ub);
    return br ? pc + br_off(w, ub) : pc + 64'd4;
  endfunction

  // Called just after a negedge; returns at the following negedge.
  task automatic step(input logic [31:0] w, input logic br, input logic ub);
    imem_rdata = w;
    brtaken    = br;
    uncondBr   = ub;
    #1;
    chk("instr", {32'h0, Instr}, {32'h0, w});
    chk("addr", imem_addr, pc_m);
`ifdef IFETCH_FLAGS_EN
    begin
      logic [64:0] s;
      logic [63:0] o, t;
      s = {1'b0, pc_m} + 65'd4;
      chk("seq_carry", {63'h0, seq_carry}, {63'h0, s[64]});
      o = br_off(w, ub);
      t = pc_m + o;
      chk("br_overflow", {63'h0, br_overflow},
          {63'h0, (pc_m[63] == o[63]) && (t[63] != pc_m[63])});
    end
`endif
    @(posedge clk);
    pc_m = ref_next(pc_m, w, br, ub);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; brtaken = 1'b0; uncondBr = 1'b0; imem_rdata = 32'hDEADBEEF;
    a = '0; b = '0; cntrl = 3'b000;
    #1;
    chk("reset_addr", imem_addr, 64'h0);
    chk("reset_instr", {32'h0, Instr}, 64'hDEADBEEF);
    @(negedge clk);
    reset = 1'b1;
    pc_m  = 64'h0;
    for (int i = 0; i < 3; i++) step($urandom, 1'b0, 1'($urandom));
    chk("three_clocks", imem_addr, 64'd12);

    // Asynchronous reset asserted mid-cycle
    #2 reset = 1'b0;
    #1 chk("async_reset", imem_addr, 64'h0);
    @(posedge clk); #1;
    chk("reset_held", imem_addr, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    pc_m  = 64'h0;

    step(32'h0, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    chk("pc8", imem_addr, 64'd8);
    step(32'h14000002, 1'b1, 1'b1);
    chk("b_fwd", imem_addr, 64'd16);
    step(32'h17FFFFFF, 1'b1, 1'b1);
    chk("b_back", imem_addr, 64'd12);
    step(32'h14000005, 1'b1, 1'b1);
    chk("pc32", imem_addr, 64'd32);
    step(32'h54FFFFC0, 1'b1, 1'b0);
    chk("cb_back", imem_addr, 64'd24);
    step(32'h14000002, 1'b1, 1'b1);
    step(32'h54000060, 1'b1, 1'b0);
    chk("cb_fwd", imem_addr, 64'd44);
    step(32'h17FFFFF6, 1'b1, 1'b1);
    chk("pc4", imem_addr, 64'd4);
    step(32'h14000010, 1'b0, 1'b1);
    chk("not_taken", imem_addr, 64'd8);
    step(32'h54FFFFA0, 1'b1, 1'b0);
    chk("pc_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step($urandom, 1'b0, 1'b0);
    chk("wrap", imem_addr, 64'h0);

    for (int i = 0; i < 300; i++)
      step($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'd1; cntrl = 3'b010;
    #1;
    chk("add_res", result, 64'h8000_0000_0000_0000);
    chk("add_ovf", {63'h0, overflow}, 64'd1);
    chk("add_neg", {63'h0, negative}, 64'd1);
    a = 64'd5; b = 64'd5; cntrl = 3'b011;
    #1;
    chk("sub_zero", {63'h0, zero}, 64'd1);
    chk("sub_carry", {63'h0, carry_out}, 64'd1);
    for (int i = 0; i < 20; i++) begin
      logic [63:0] e;
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; cntrl = 3'($urandom);
      case (cntrl)
        3'b000:  e = b;
        3'b010:  e = a + b;
        3'b011:  e = a - b;
        3'b100:  e = a & b;
        3'b101:  e = a | b;
        3'b110:  e = a ^ b;
        default: e = 64'h0;
      endcase
      #1;
      chk("alu_rand", result, e);
      chk("alu_zero", {63'h0, zero}, {63'h0, e == 64'h0});
      if (cntrl[2] || cntrl == 3'b000) chk("alu_logic_c", {63'h0, carry_out}, 64'h0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
